// File: rtl/mult_bus_pkg.sv
// Shared types and constants for the multiplier peripheral bus master.
package mult_bus_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OP_W    = 16;
    localparam int unsigned WDATA_W = 16;
    localparam int unsigned RDATA_W = 32;
    localparam int unsigned RES_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_OPA  = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_OPB  = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 5'h08;
    localparam int unsigned       STAT_DONE_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_A   = 3'd1,
        ST_WR_B   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_POLL   = 3'd4,
        ST_RD_RES = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

    typedef struct packed {
        logic               cs;
        logic               rd;
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } bus_req_t;

    // Moore bus decode: what the peripheral bus shows while in a given state.
    function automatic bus_req_t bus_decode(input state_e           st,
                                            input logic [OP_W-1:0]  op_a,
                                            input logic [OP_W-1:0]  op_b);
        bus_req_t b;
        b = '0;
        case (st)
            ST_WR_A: begin
                b.cs    = 1'b1;
                b.wr    = 1'b1;
                b.addr  = ADDR_OPA;
                b.wdata = WDATA_W'(op_a);
            end
            ST_WR_B: begin
                b.cs    = 1'b1;
                b.wr    = 1'b1;
                b.addr  = ADDR_OPB;
                b.wdata = WDATA_W'(op_b);
            end
            // Status is read with rd low; rd high at this address returns the result word.
            ST_POLL: begin
                b.cs   = 1'b1;
                b.addr = ADDR_STAT;
            end
            ST_RD_RES: begin
                b.cs   = 1'b1;
                b.rd   = 1'b1;
                b.addr = ADDR_OPB;
            end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mult_bus_master.sv
// Host-side job sequencer driving an external multiplier peripheral:
// write operands, settle, poll status with timeout, read the product.
module mult_bus_master
    import mult_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    req_op_a,
    input  logic [OP_W-1:0]    req_op_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RES_W-1:0]   rsp_result,
    output logic               rsp_err,
    output logic               bus_cs,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic               bus_rd,
    output logic               bus_wr,
    output logic [WDATA_W-1:0] bus_wdata,
    input  logic [RDATA_W-1:0] bus_rdata,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SET_W = 3;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [OP_W-1:0]    op_a_q, op_a_d;
    logic [OP_W-1:0]    op_b_q, op_b_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q, err_d;
    bus_req_t           bus_q, bus_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               done_c;

    assign done_c = bus_rdata[STAT_DONE_BIT];

    // Next state plus registered outputs decoded from the upcoming state.
    always_comb begin
        state_d      = state_q;
        poll_cnt_d   = poll_cnt_q;
        settle_cnt_d = settle_cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_a_d  = req_op_a;
                    op_b_d  = req_op_b;
                    state_d = ST_WR_A;
                end
            end
            ST_WR_A: state_d = ST_WR_B;
            ST_WR_B: begin
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            // Quiet gap so a done flag left over from the previous job is not seen.
            ST_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    poll_cnt_d = '0;
                    state_d    = ST_POLL;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            // Done takes priority over a timeout landing in the same cycle.
            ST_POLL: begin
                poll_cnt_d = poll_cnt_q + CNT_W'(1);
                if (done_c) begin
                    state_d = ST_RD_RES;
                end else if (poll_cnt_d == CNT_W'(TIMEOUT)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = ST_RESP;
                end
            end
            ST_RD_RES: begin
                result_d = RES_W'(bus_rdata);
                err_d    = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus_d       = bus_decode(state_d, op_a_d, op_b_d);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            poll_cnt_q   <= '0;
            settle_cnt_q <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            bus_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            bus_q        <= bus_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign bus_cs     = bus_q.cs;
    assign bus_rd     = bus_q.rd;
    assign bus_wr     = bus_q.wr;
    assign bus_addr   = bus_q.addr;
    assign bus_wdata  = bus_q.wdata;

endmodule

// File: tb/tb_mult_bus_master.sv
// Directed bench for mult_bus_master with a small behavioural multiplier peripheral.
module tb_mult_bus_master;
    import mult_bus_pkg::*;

    localparam int unsigned TO = 16;
    localparam int unsigned SC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_op_a = '0;
    logic [15:0] req_op_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        bus_cs;
    logic [4:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mult_bus_master #(.TIMEOUT(TO), .SETTLE_CYC(SC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .bus_cs(bus_cs), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral model: done_mode 0 = done after done_after polls, 1 = never, 2 = stuck high.
    logic [15:0] per_a = '0;
    logic [15:0] per_b = '0;
    int          poll_seen = 0;
    int          rd_seen = 0;
    int          done_mode = 0;
    int          done_after = 3;
    logic        per_done;

    always_comb per_done = (done_mode == 2) || (done_mode == 0 && poll_seen >= done_after);

    always_comb begin
        if (bus_cs && bus_rd)
            bus_rdata = 32'(per_a) * 32'(per_b);
        else if (bus_cs && !bus_wr && bus_addr == ADDR_STAT)
            bus_rdata = {31'b0, per_done};
        else
            bus_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus_cs && bus_wr && bus_addr == ADDR_OPA) begin
            per_a     <= bus_wdata;
            poll_seen <= 0;
        end else if (bus_cs && bus_wr && bus_addr == ADDR_OPB) begin
            per_b <= bus_wdata;
        end else if (bus_cs && !bus_rd && bus_addr == ADDR_STAT) begin
            poll_seen <= poll_seen + 1;
        end
        if (bus_cs && bus_rd) rd_seen <= rd_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle; returns one cycle later (WR_A cycle).
    task automatic start_job(input logic [15:0] a, input logic [15:0] b);
        req_op_a  = a;
        req_op_b  = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        checks++;
        if ({rsp_valid, rsp_err, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_flags: got %b want 000", {rsp_valid, rsp_err, busy});
        end
        checks++;
        if (rsp_result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", rsp_result); end
        checks++;
        if ({bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata} !== 24'h0) begin
            errors++; $display("FAIL rst_bus: got %h want 0", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        done_mode  = 0;
        done_after = 3;
        start_job(16'd3, 16'd5);
        checks++;
        if ({bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata} !== {3'b101, 5'h00, 16'd3}) begin
            errors++; $display("FAIL basic_wr_a: got %h want %h", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata}, {3'b101, 5'h00, 16'd3});
        end
        checks++;
        if ({req_ready, busy} !== 2'b01) begin errors++; $display("FAIL basic_busy: got %b want 01", {req_ready, busy}); end
        tick();
        checks++;
        if ({bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata} !== {3'b101, 5'h04, 16'd5}) begin
            errors++; $display("FAIL basic_wr_b: got %h want %h", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata}, {3'b101, 5'h04, 16'd5});
        end
        wait_rsp(n);
        checks++;
        if (n + 2 != int'(SC + 8)) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n + 2, SC + 8); end
        checks++;
        if ({rsp_err, rsp_result} !== {1'b0, 32'h0000000F}) begin
            errors++; $display("FAIL basic_result: got %b %h want 0 0000000f", rsp_err, rsp_result);
        end
        checks++;
        if (poll_seen != 4) begin errors++; $display("FAIL basic_polls: got %0d want 4", poll_seen); end
        handshake();
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL basic_idle: got %b want 100", {req_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_max_operands();
        int n;
        done_mode  = 0;
        done_after = 1;
        start_job(16'hFFFF, 16'hFFFF);
        req_valid = 1'b1;
        req_op_a  = 16'h1234;
        req_op_b  = 16'h5678;
        wait_rsp(n);
        req_valid = 1'b0;
        checks++;
        if ({rsp_err, rsp_result} !== {1'b0, 32'hFFFE0001}) begin
            errors++; $display("FAIL max_result: got %b %h want 0 fffe0001", rsp_err, rsp_result);
        end
        checks++;
        if (per_b !== 16'hFFFF) begin errors++; $display("FAIL max_op_b_held: got %h want ffff", per_b); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL max_req_ready: got %b want 0", req_ready); end
        handshake();
    endtask

    task automatic test_timeout();
        int n;
        int r0;
        done_mode = 1;
        r0 = rd_seen;
        start_job(16'd9, 16'd9);
        wait_rsp(n);
        checks++;
        if (n + 1 != int'(SC + 3 + TO)) begin errors++; $display("FAIL to_latency: got %0d want %0d", n + 1, SC + 3 + TO); end
        checks++;
        if (poll_seen != int'(TO)) begin errors++; $display("FAIL to_polls: got %0d want %0d", poll_seen, TO); end
        checks++;
        if (rd_seen != r0) begin errors++; $display("FAIL to_no_rd: got %0d want %0d", rd_seen, r0); end
        checks++;
        if ({rsp_err, rsp_result} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL to_result: got %b %h want 1 00000000", rsp_err, rsp_result);
        end
        handshake();
    endtask

    task automatic test_hold();
        int n;
        done_mode  = 0;
        done_after = 0;
        start_job(16'h1234, 16'h0010);
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_result} !== {2'b10, 32'h00012340}) begin
                errors++; $display("FAIL hold_rsp[%0d]: got %b %b %h want 1 0 00012340", i, rsp_valid, req_ready, rsp_result);
            end
            checks++;
            if ({bus_cs, bus_rd, bus_wr} !== 3'b000) begin
                errors++; $display("FAIL hold_bus[%0d]: got %b want 000", i, {bus_cs, bus_rd, bus_wr});
            end
            tick();
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        int k;
        done_mode = 1;
        start_job(16'd7, 16'd9);
        k = 0;
        while (!(bus_cs && bus_addr == ADDR_STAT) && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (bus_addr !== ADDR_STAT) begin errors++; $display("FAIL rmid_reach_poll: got %h want 08", bus_addr); end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata} !== 24'h0) begin
            errors++; $display("FAIL rmid_bus: got %h want 0", {bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata});
        end
        checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            errors++; $display("FAIL rmid_flags: got %b want 010", {rsp_valid, req_ready, busy});
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus_cs, rsp_valid} !== 2'b00) begin
                errors++; $display("FAIL rmid_quiet[%0d]: got %b want 00", i, {bus_cs, rsp_valid});
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int q;
        done_mode = 2;
        start_job(16'd2, 16'd7);
        wait_rsp(n);
        checks++;
        if (rsp_result !== 32'd14) begin errors++; $display("FAIL b2b_job1: got %h want 0000000e", rsp_result); end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op_a  = 16'd4;
        req_op_b  = 16'd6;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_idle: got %b want 10", {req_ready, rsp_valid});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({bus_cs, bus_wr, bus_addr, bus_wdata} !== {2'b11, 5'h00, 16'd4}) begin
            errors++; $display("FAIL b2b_wr_a: got %h want %h", {bus_cs, bus_wr, bus_addr, bus_wdata}, {2'b11, 5'h00, 16'd4});
        end
        tick();
        tick();
        q = 0;
        while (!bus_cs && q < 20) begin
            q++;
            tick();
        end
        checks++;
        if (q != int'(SC)) begin errors++; $display("FAIL b2b_settle: got %0d want %0d", q, SC); end
        checks++;
        if ({bus_rd, bus_addr} !== {1'b0, ADDR_STAT}) begin
            errors++; $display("FAIL b2b_first_poll: got %h want 08", {bus_rd, bus_addr});
        end
        wait_rsp(n);
        checks++;
        if ({rsp_err, rsp_result} !== {1'b0, 32'd24}) begin
            errors++; $display("FAIL b2b_job2: got %b %h want 0 00000018", rsp_err, rsp_result);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_operands();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_bus_master.md
MULT_BUS_MASTER -- requirements
Module: mult_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 1024, max POLL cycles before error; legal 2..65535.
REQ-002 Parameter SETTLE_CYC, default 2, idle cycles between op_B write and first status poll; legal 1..7.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 req_valid  in  1  host job request.
REQ-006 req_ready  out  1  block can accept a job.
REQ-007 req_op_a  in  16  operand A.
REQ-008 req_op_b  in  16  operand B.
REQ-009 rsp_valid  out  1  job response available.
REQ-010 rsp_ready  in  1  host accepts response.
REQ-011 rsp_result  out  32  product; 0 on error.
REQ-012 rsp_err  out  1  1 = timeout.
REQ-013 bus_cs  out  1  peripheral chip select.
REQ-014 bus_addr  out  5  peripheral register address.
REQ-015 bus_rd  out  1  read strobe.
REQ-016 bus_wr  out  1  write strobe.
REQ-017 bus_wdata  out  16  write data.
REQ-018 bus_rdata  in  32  peripheral read data; combinational from bus_addr/bus_cs/bus_rd.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states IDLE, WR_A, WR_B, SETTLE, POLL, RD_RES, RESP; one transition per cycle max.
REQ-021 IDLE: req_ready=1; req_valid&req_ready captures both operands into internal registers, next WR_A.
REQ-022 WR_A (1 cycle): cs=1, addr=0x00, wr=1, rd=0, wdata=op_a; next WR_B.
REQ-023 WR_B (1 cycle): cs=1, addr=0x04, wr=1, rd=0, wdata=op_b; next SETTLE.
REQ-024 SETTLE: cs=0, rd=0, wr=0 for exactly SETTLE_CYC cycles; next POLL; masks stale done from the previous job.
REQ-025 POLL: cs=1, addr=0x08, rd=0, wr=0; bus_rdata[0] sampled same cycle; 1 -> RD_RES, else stay.
REQ-026 Status poll uses rd=0, since rd=1 at 0x08 returns the result word rather than status.
REQ-027 Poll counter clears on POLL entry, increments each POLL cycle; reaching TIMEOUT with done still 0 -> RESP with err flag set, result register 0.
REQ-028 Done seen in the same cycle the counter reaches TIMEOUT: done wins, no error.
REQ-029 RD_RES (1 cycle): cs=1, addr=0x04, rd=1, wr=0; bus_rdata captured into result register at end of cycle; next RESP.
REQ-030 RESP: rsp_valid=1, rsp_result/rsp_err held stable until rsp_valid&rsp_ready; then IDLE.
REQ-031 Outside WR_A/WR_B/POLL/RD_RES: bus_cs=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_wdata=0.
REQ-032 Bus outputs are a Moore decode of the state register only; no input-to-output combinational path.
REQ-033 Latency, request accepted cycle T, done first seen cycle P: WR_A T+1, WR_B T+2, POLL from T+3+SETTLE_CYC, RD_RES P+1, rsp_valid P+2.
REQ-034 req_ready=0 in all non-IDLE states; operands unaffected by req_* changes mid-job.
REQ-035 Back-to-back: rsp handshake at cycle R -> IDLE at R+1; new request accepted earliest R+1.

Reset
REQ-036 While reset=0 at a clock edge: state IDLE, counters 0, operand/result registers 0.
REQ-037 Outputs during/after reset: req_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, all bus outputs 0.
REQ-038 Reset mid-job aborts with no response issued and no further bus cycles from the next cycle.

Structure
REQ-039 Shared package mult_bus_pkg: state enum, ADDR_OPA=5'h00, ADDR_OPB=5'h04, ADDR_STAT=5'h08, STAT_DONE_BIT=0.
REQ-040 Single module, no sub-module; poll counter width $clog2(TIMEOUT+1).

Verification
REQ-041 op 3,5; done after 3 polls -> WR_A wdata 3, WR_B wdata 5, rsp_result 0x0000000F, err 0, rsp_valid at T+SETTLE_CYC+8.
REQ-042 op 0xFFFF,0xFFFF -> rsp_result 0xFFFE0001, err 0.
REQ-043 done held 0, TIMEOUT=16 -> exactly 16 POLL cycles, no RD_RES, rsp_err 1, result 0.
REQ-044 rsp_ready low 5 cycles in RESP -> rsp_valid/result stable, req_ready 0, no bus activity.
REQ-045 reset=0 during POLL -> next cycle all bus outputs 0, rsp_valid 0, req_ready 1.
REQ-046 Two jobs back-to-back, done stuck high from job 1 -> job 2 still observes SETTLE_CYC quiet cycles before first POLL.
